// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 32-point MDC FFT datapath.
// Holds the Q1.7 W32 cos/sin quarter tables used by the stage twiddle multipliers.
// Also provides the rounding constants and a generic signed saturation helper.
package fft_pkg;

    localparam int TW_W        = 9;
    localparam int TW_FRAC     = 7;
    localparam int ROUND_CONST = 64;

    // One twiddle factor, real and imaginary parts in Q1.7.
    typedef struct packed {
        logic signed [TW_W-1:0] wr;
        logic signed [TW_W-1:0] wi;
    } tw_t;

    // cos(2*pi*j/32) and sin(2*pi*j/32) for j = 0..7, scaled by 128.
    localparam logic signed [TW_W-1:0] TW_COS [8] = '{
        9'sd128, 9'sd125, 9'sd118, 9'sd106, 9'sd90, 9'sd71, 9'sd48, 9'sd24
    };
    localparam logic signed [TW_W-1:0] TW_SIN [8] = '{
        9'sd0, 9'sd24, 9'sd48, 9'sd71, 9'sd90, 9'sd106, 9'sd118, 9'sd125
    };

    // Clamp a wide signed value to the range of a w-bit signed number.
    // The caller truncates the result to w bits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                               input int unsigned      w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            sat = hi;
        else if (x < lo)
            sat = lo;
        else
            sat = x;
    endfunction

endpackage

// File: rtl/twiddle_lut16.sv
// W32^k lookup for k = 0..15 (first half of the unit circle, clockwise).
// Latency: purely combinational.
// Backpressure: none, no state.
module twiddle_lut16 import fft_pkg::*; (
    input  logic [3:0] k,
    output tw_t        tw
);

    // Quadrant 0 uses (c, -s); quadrant 1 rotates by -j giving (-s, -c).
    always_comb begin
        tw.wr = '0;
        tw.wi = '0;
        if (!k[3]) begin
            tw.wr = TW_COS[k[2:0]];
            tw.wi = -TW_SIN[k[2:0]];
        end else begin
            tw.wr = -TW_SIN[k[2:0]];
            tw.wi = -TW_COS[k[2:0]];
        end
    end

endmodule

// File: rtl/twiddle_mult16.sv
// Stage twiddle multiplier: counts the index k and multiplies each sample by W32^k.
// Latency: 3 cycles input to output (register, multiply, round/saturate).
// Backpressure: none; accepts one sample on every in_valid cycle.
module twiddle_mult16 import fft_pkg::*; #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sync,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic [3:0]               out_k
);

    localparam int PW = DATA_W + TW_W;  // product width
    localparam int SW = PW + 1;         // sum width

    logic [3:0] cnt;
    logic [3:0] eff_k;
    tw_t        tw;

    // A sync overrides the running index so the frame starts at k = 0.
    assign eff_k = in_sync ? 4'd0 : cnt;

    twiddle_lut16 u_lut (
        .k  (eff_k),
        .tw (tw)
    );

    // Index counter: advances past the index just used; a lone sync rewinds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (in_valid)
            cnt <= eff_k + 4'd1;
        else if (in_sync)
            cnt <= '0;
    end

    logic                     s1_vld;
    logic [3:0]               s1_k;
    logic signed [DATA_W-1:0] s1_re;
    logic signed [DATA_W-1:0] s1_im;
    logic signed [TW_W-1:0]   s1_wr;
    logic signed [TW_W-1:0]   s1_wi;

    // S1: capture the sample together with its twiddle and index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_k   <= '0;
            s1_re  <= '0;
            s1_im  <= '0;
            s1_wr  <= '0;
            s1_wi  <= '0;
        end else begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_k  <= eff_k;
                s1_re <= in_re;
                s1_im <= in_im;
                s1_wr <= tw.wr;
                s1_wi <= tw.wi;
            end
        end
    end

    logic                 s2_vld;
    logic [3:0]           s2_k;
    logic signed [PW-1:0] s2_rr;
    logic signed [PW-1:0] s2_ii;
    logic signed [PW-1:0] s2_ri;
    logic signed [PW-1:0] s2_ir;

    // S2: the four partial products of the complex multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_k   <= '0;
            s2_rr  <= '0;
            s2_ii  <= '0;
            s2_ri  <= '0;
            s2_ir  <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_k  <= s1_k;
                s2_rr <= PW'(s1_re) * PW'(s1_wr);
                s2_ii <= PW'(s1_im) * PW'(s1_wi);
                s2_ri <= PW'(s1_re) * PW'(s1_wi);
                s2_ir <= PW'(s1_im) * PW'(s1_wr);
            end
        end
    end

    logic signed [SW-1:0] re_sum;
    logic signed [SW-1:0] im_sum;
    logic signed [SW-1:0] re_rnd;
    logic signed [SW-1:0] im_rnd;

    // Combine products, then round half toward +inf back to Q0 scaling.
    always_comb begin
        re_sum = SW'(s2_rr) - SW'(s2_ii);
        im_sum = SW'(s2_ri) + SW'(s2_ir);
        re_rnd = (re_sum + SW'(ROUND_CONST)) >>> TW_FRAC;
        im_rnd = (im_sum + SW'(ROUND_CONST)) >>> TW_FRAC;
    end

    // S3: saturate and register the result; outputs hold between samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_k     <= '0;
        end else begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                out_re <= DATA_W'(sat(64'(re_rnd), DATA_W));
                out_im <= DATA_W'(sat(64'(im_rnd), DATA_W));
                out_k  <= s2_k;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_mult16.sv
// Directed and model-based bench for twiddle_mult16.
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
// Each drive() is one clock; a sample driven in call n is visible after call n+2.
module tb_twiddle_mult16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_sync = 1'b0;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;
    logic               out_valid;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;
    logic [3:0]         out_k;

    int checks = 0;
    int errors = 0;

    int cos_t [8] = '{128, 125, 118, 106, 90, 71, 48, 24};
    int sin_t [8] = '{0, 24, 48, 71, 90, 106, 118, 125};

    twiddle_mult16 #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_k     (out_k)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit v, input bit s, input int re, input int im);
        in_valid = v;
        in_sync  = s;
        in_re    = re[15:0];
        in_im    = im[15:0];
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_sat(input longint x);
        longint r;
        r = (x + 64) >>> 7;
        if (r > 32767)
            r = 32767;
        else if (r < -32768)
            r = -32768;
        return int'(r);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (int'(out_re) !== 0) begin errors++; $display("FAIL reset_re got %0d want 0", out_re); end
        checks++; if (int'(out_im) !== 0) begin errors++; $display("FAIL reset_im got %0d want 0", out_im); end
        checks++; if (out_k !== 4'd0) begin errors++; $display("FAIL reset_k got %0d want 0", out_k); end
        rst = 1'b0;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_first_sample();
        drive(1, 1, 1000, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_early1 got %0b want 0", out_valid); end
        drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_early2 got %0b want 0", out_valid); end
        drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %0b want 1", out_valid); end
        checks++; if (int'(out_re) !== 1000) begin errors++; $display("FAIL first_re got %0d want 1000", out_re); end
        checks++; if (int'(out_im) !== 0) begin errors++; $display("FAIL first_im got %0d want 0", out_im); end
        checks++; if (out_k !== 4'd0) begin errors++; $display("FAIL first_k got %0d want 0", out_k); end
        drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_pulse got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        drive(1, 0, 500, 500);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_during got %0b want 0", out_valid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_after%0d got %0b want 0", c, out_valid); end
        end
    endtask

    task automatic test_sweep();
        int j, er, ei;
        for (int c = 0; c < 19; c++) begin
            drive(c <= 16, c == 0, 1000, 0);
            if (c >= 2) begin
                j = c - 2;
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid j=%0d got %0b want 1", j, out_valid); end
                checks++; if (int'(out_k) !== j % 16) begin errors++; $display("FAIL sweep_k j=%0d got %0d want %0d", j, out_k, j % 16); end
                er = 99999;
                ei = 99999;
                case (j)
                    0, 16: begin er = 1000; ei = 0;     end
                    4:     begin er = 703;  ei = -703;  end
                    8:     begin er = 0;    ei = -1000; end
                    12:    begin er = -703; ei = -703;  end
                    default: ;
                endcase
                if (er != 99999) begin
                    checks++; if (int'(out_re) !== er) begin errors++; $display("FAIL sweep_re j=%0d got %0d want %0d", j, out_re, er); end
                    checks++; if (int'(out_im) !== ei) begin errors++; $display("FAIL sweep_im j=%0d got %0d want %0d", j, out_im, ei); end
                end
            end
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        int dr, di;
        for (int c = 0; c < 11; c++) begin
            dr = 0;
            di = 0;
            if (c == 4) begin dr = 32767; di = 32767; end
            if (c == 8) begin dr = -32768; di = 0; end
            drive(c <= 8, c == 0, dr, di);
            if (c == 6) begin
                checks++; if (out_k !== 4'd4) begin errors++; $display("FAIL sat_pos_k got %0d want 4", out_k); end
                checks++; if (int'(out_re) !== 32767) begin errors++; $display("FAIL sat_pos_re got %0d want 32767", out_re); end
                checks++; if (int'(out_im) !== 0) begin errors++; $display("FAIL sat_pos_im got %0d want 0", out_im); end
            end
            if (c == 10) begin
                checks++; if (out_k !== 4'd8) begin errors++; $display("FAIL sat_neg_k got %0d want 8", out_k); end
                checks++; if (int'(out_re) !== 0) begin errors++; $display("FAIL sat_neg_re got %0d want 0", out_re); end
                checks++; if (int'(out_im) !== 32767) begin errors++; $display("FAIL sat_neg_im got %0d want 32767", out_im); end
            end
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
    endtask

    task automatic test_gaps();
        bit vin [8]  = '{0, 1, 0, 1, 1, 0, 0, 0};
        bit sin [8]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        bit ev  [8]  = '{0, 0, 0, 1, 0, 1, 1, 0};
        int ek  [8]  = '{0, 0, 0, 0, 0, 1, 2, 0};
        int ere [8]  = '{0, 0, 0, 1000, 0, 977, 922, 0};
        int eim [8]  = '{0, 0, 0, 0, 0, -187, -375, 0};
        for (int c = 0; c < 8; c++) begin
            drive(vin[c], sin[c], 1000, 0);
            if (c >= 2) begin
                checks++; if (out_valid !== ev[c]) begin errors++; $display("FAIL gap_valid c=%0d got %0b want %0b", c, out_valid, ev[c]); end
                if (ev[c]) begin
                    checks++; if (int'(out_k) !== ek[c]) begin errors++; $display("FAIL gap_k c=%0d got %0d want %0d", c, out_k, ek[c]); end
                    checks++; if (int'(out_re) !== ere[c]) begin errors++; $display("FAIL gap_re c=%0d got %0d want %0d", c, out_re, ere[c]); end
                    checks++; if (int'(out_im) !== eim[c]) begin errors++; $display("FAIL gap_im c=%0d got %0d want %0d", c, out_im, eim[c]); end
                end
            end
        end
    endtask

    task automatic test_sync();
        bit vin [17] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        bit sin [17] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        int ek  [17] = '{0, 1, 2, 3, 4, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 0, 1};
        int j;
        for (int c = 0; c < 19; c++) begin
            if (c < 17)
                drive(vin[c], sin[c], 1000, 0);
            else
                drive(0, 0, 0, 0);
            if (c >= 2) begin
                j = c - 2;
                checks++; if (out_valid !== vin[j]) begin errors++; $display("FAIL sync_valid j=%0d got %0b want %0b", j, out_valid, vin[j]); end
                if (vin[j]) begin
                    checks++; if (int'(out_k) !== ek[j]) begin errors++; $display("FAIL sync_k j=%0d got %0d want %0d", j, out_k, ek[j]); end
                end
            end
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit pv [3]  = '{0, 0, 0};
        int pk [3]  = '{0, 0, 0};
        int pre [3] = '{0, 0, 0};
        int pim [3] = '{0, 0, 0};
        int mcnt, k, ar, ai, wr, wi;
        bit v, s;
        mcnt = 0;
        for (int c = 0; c < 2002; c++) begin
            v = (c < 2000) && ($urandom_range(3) != 0);
            s = (c == 0) || ((c < 2000) && ($urandom_range(19) == 0));
            if ($urandom_range(7) == 0) begin
                ar = $urandom_range(1) ? 32767 : -32768;
                ai = $urandom_range(1) ? 32767 : -32768;
            end else begin
                ar = int'($urandom_range(65535)) - 32768;
                ai = int'($urandom_range(65535)) - 32768;
            end
            k = s ? 0 : mcnt;
            if (v)
                mcnt = (k + 1) % 16;
            else if (s)
                mcnt = 0;
            if (k < 8) begin
                wr = cos_t[k];
                wi = -sin_t[k];
            end else begin
                wr = -sin_t[k - 8];
                wi = -cos_t[k - 8];
            end
            for (int i = 2; i > 0; i--) begin
                pv[i] = pv[i-1]; pk[i] = pk[i-1]; pre[i] = pre[i-1]; pim[i] = pim[i-1];
            end
            pv[0]  = v;
            pk[0]  = k;
            pre[0] = rnd_sat(longint'(ar) * wr - longint'(ai) * wi);
            pim[0] = rnd_sat(longint'(ar) * wi + longint'(ai) * wr);
            drive(v, s, ar, ai);
            checks++; if (out_valid !== pv[2]) begin errors++; $display("FAIL rand_valid c=%0d got %0b want %0b", c, out_valid, pv[2]); end
            if (pv[2]) begin
                checks++; if (int'(out_k) !== pk[2]) begin errors++; $display("FAIL rand_k c=%0d got %0d want %0d", c, out_k, pk[2]); end
                checks++; if (int'(out_re) !== pre[2]) begin errors++; $display("FAIL rand_re c=%0d got %0d want %0d", c, out_re, pre[2]); end
                checks++; if (int'(out_im) !== pim[2]) begin errors++; $display("FAIL rand_im c=%0d got %0d want %0d", c, out_im, pim[2]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_reset_midstream();
        test_sweep();
        test_saturation();
        test_gaps();
        test_sync();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
